// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: LANES write-back ops plus bundle PC, valid/ready with a
// two-entry skid buffer, registered in_ready_o, flush, and a retired-bundle counter.
module mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 16,
   parameter int LANES  = 2,
   parameter int CNT_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [LANES-1:0]          lane_wen_i,
   input  logic [LANES*ADDR_W-1:0]   lane_waddr_i,
   input  logic [LANES*DATA_W-1:0]   lane_wdata_i,
   input  logic [PC_W-1:0]           pc_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [LANES-1:0]          lane_wen_o,
   output logic [LANES*ADDR_W-1:0]   lane_waddr_o,
   output logic [LANES*DATA_W-1:0]   lane_wdata_o,
   output logic [PC_W-1:0]           pc_o,
   output logic [CNT_W-1:0]          retire_cnt_o
);

   logic                    main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic                    in_ready_q, in_ready_d;
   logic [LANES-1:0]        main_wen_q, main_wen_d, skid_wen_q, skid_wen_d;
   logic [LANES*ADDR_W-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
   logic [LANES*DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [PC_W-1:0]         main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [LANES-1:0]        cap_wen;
   logic                    accept, retire;

   // Write-enable cleanup at capture: drop r0 writes and any lane shadowed by a higher lane.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_clean
      logic keep;
      always_comb begin
         keep = lane_wen_i[gi] && (lane_waddr_i[gi*ADDR_W +: ADDR_W] != '0);
         for (int j = gi + 1; j < LANES; j++) begin
            if (lane_wen_i[j] &&
                (lane_waddr_i[j*ADDR_W +: ADDR_W] == lane_waddr_i[gi*ADDR_W +: ADDR_W]))
               keep = 1'b0;
         end
      end
      assign cap_wen[gi] = keep;
   end

   assign accept = in_valid_i & in_ready_q & ~flush_i;
   assign retire = main_v_q & out_ready_i & ~flush_i;

   always_comb begin
      main_v_d    = main_v_q;
      skid_v_d    = skid_v_q;
      main_wen_d  = main_wen_q;
      main_addr_d = main_addr_q;
      main_data_d = main_data_q;
      main_pc_d   = main_pc_q;
      skid_wen_d  = skid_wen_q;
      skid_addr_d = skid_addr_q;
      skid_data_d = skid_data_q;
      skid_pc_d   = skid_pc_q;
      cnt_d       = cnt_q + (retire ? CNT_W'(1) : CNT_W'(0));
      if (flush_i) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else begin
         case ({main_v_q, skid_v_q})
            2'b00: begin
               if (accept) begin
                  main_v_d    = 1'b1;
                  main_wen_d  = cap_wen;
                  main_addr_d = lane_waddr_i;
                  main_data_d = lane_wdata_i;
                  main_pc_d   = pc_i;
               end
            end
            2'b10: begin
               if (accept && retire) begin
                  main_wen_d  = cap_wen;
                  main_addr_d = lane_waddr_i;
                  main_data_d = lane_wdata_i;
                  main_pc_d   = pc_i;
               end else if (accept) begin
                  skid_v_d    = 1'b1;
                  skid_wen_d  = cap_wen;
                  skid_addr_d = lane_waddr_i;
                  skid_data_d = lane_wdata_i;
                  skid_pc_d   = pc_i;
               end else if (retire) begin
                  main_v_d = 1'b0;
               end
            end
            default: begin
               // Skid full: in_ready_q is low, so only a retire can move things.
               if (retire) begin
                  skid_v_d    = 1'b0;
                  main_wen_d  = skid_wen_q;
                  main_addr_d = skid_addr_q;
                  main_data_d = skid_data_q;
                  main_pc_d   = skid_pc_q;
               end
            end
         endcase
      end
      in_ready_d = ~skid_v_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_v_q    <= 1'b0;
         skid_v_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         main_wen_q  <= '0;
         main_addr_q <= '0;
         main_data_q <= '0;
         main_pc_q   <= '0;
         skid_wen_q  <= '0;
         skid_addr_q <= '0;
         skid_data_q <= '0;
         skid_pc_q   <= '0;
         cnt_q       <= '0;
      end else begin
         main_v_q    <= main_v_d;
         skid_v_q    <= skid_v_d;
         in_ready_q  <= in_ready_d;
         main_wen_q  <= main_wen_d;
         main_addr_q <= main_addr_d;
         main_data_q <= main_data_d;
         main_pc_q   <= main_pc_d;
         skid_wen_q  <= skid_wen_d;
         skid_addr_q <= skid_addr_d;
         skid_data_q <= skid_data_d;
         skid_pc_q   <= skid_pc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready_o   = in_ready_q;
   assign out_valid_o  = main_v_q;
   assign lane_wen_o   = main_v_q ? main_wen_q  : '0;
   assign lane_waddr_o = main_v_q ? main_addr_q : '0;
   assign lane_wdata_o = main_v_q ? main_data_q : '0;
   assign pc_o         = main_v_q ? main_pc_q   : '0;
   assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe (LANES=2, CNT_W=4): vector table plus hand sequences
// for skid fill, flush, counter wrap and asynchronous reset.
module tb_mem_wb_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [1:0]  lane_wen_i = '0;
   logic [9:0]  lane_waddr_i = '0;
   logic [63:0] lane_wdata_i = '0;
   logic [15:0] pc_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [1:0]  lane_wen_o;
   logic [9:0]  lane_waddr_o;
   logic [63:0] lane_wdata_o;
   logic [15:0] pc_o;
   logic [3:0]  retire_cnt_o;

   int n_checks = 0;
   int n_err    = 0;

   mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .PC_W(16), .LANES(2), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .lane_wen_i(lane_wen_i), .lane_waddr_i(lane_waddr_i), .lane_wdata_i(lane_wdata_i),
      .pc_i(pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .lane_wen_o(lane_wen_o), .lane_waddr_o(lane_waddr_o), .lane_wdata_o(lane_wdata_o),
      .pc_o(pc_o), .retire_cnt_o(retire_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic        ordy;
      logic [1:0]  wen;
      logic [9:0]  waddr;
      logic [63:0] wdata;
      logic [15:0] pc;
      logic        e_valid;
      logic        e_ready;
      logic [1:0]  e_wen;
      logic [15:0] e_pc;
      logic [63:0] e_wdata;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(logic iv, logic ordy, logic [1:0] wen, logic [9:0] waddr,
                               logic [63:0] wdata, logic [15:0] pc, logic e_valid,
                               logic e_ready, logic [1:0] e_wen, logic [15:0] e_pc,
                               logic [63:0] e_wdata, logic [3:0] e_cnt);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.pc = pc;
      v.e_valid = e_valid; v.e_ready = e_ready; v.e_wen = e_wen; v.e_pc = e_pc;
      v.e_wdata = e_wdata; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
      lane_wen_i = '0; lane_waddr_i = '0; lane_wdata_i = '0; pc_i = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   localparam logic [63:0] DAB = {32'hBBBB0001, 32'hAAAA0001};
   localparam logic [63:0] DCD = {32'hDDDD0002, 32'hCCCC0002};
   localparam logic [63:0] DEF = {32'hFFFF0003, 32'hEEEE0003};
   localparam logic [63:0] DGH = {32'h99990004, 32'h88880004};

   initial begin
      // Streaming at full rate
      vecs[0]  = mk(1, 1, 2'b00, 10'd0, 64'd0, 16'h0010, 1, 1, 2'b00, 16'h0010, 64'd0, 4'd0);
      vecs[1]  = mk(1, 1, 2'b00, 10'd0, 64'd0, 16'h0011, 1, 1, 2'b00, 16'h0011, 64'd0, 4'd1);
      vecs[2]  = mk(1, 1, 2'b00, 10'd0, 64'd0, 16'h0012, 1, 1, 2'b00, 16'h0012, 64'd0, 4'd2);
      vecs[3]  = mk(1, 1, 2'b00, 10'd0, 64'd0, 16'h0013, 1, 1, 2'b00, 16'h0013, 64'd0, 4'd3);
      vecs[4]  = mk(0, 1, 2'b00, 10'd0, 64'd0, 16'h0000, 0, 1, 2'b00, 16'h0000, 64'd0, 4'd4);
      // WB stall fills the skid, then drains in order
      vecs[5]  = mk(1, 0, 2'b00, 10'd0, 64'd0, 16'h0020, 1, 1, 2'b00, 16'h0020, 64'd0, 4'd4);
      vecs[6]  = mk(1, 0, 2'b00, 10'd0, 64'd0, 16'h0024, 1, 0, 2'b00, 16'h0020, 64'd0, 4'd4);
      vecs[7]  = mk(1, 0, 2'b00, 10'd0, 64'd0, 16'h0099, 1, 0, 2'b00, 16'h0020, 64'd0, 4'd4);
      vecs[8]  = mk(0, 1, 2'b00, 10'd0, 64'd0, 16'h0000, 1, 1, 2'b00, 16'h0024, 64'd0, 4'd5);
      vecs[9]  = mk(0, 1, 2'b00, 10'd0, 64'd0, 16'h0000, 0, 1, 2'b00, 16'h0000, 64'd0, 4'd6);
      // Lane cleanup: same-address conflict, r0 writes, independent lanes
      vecs[10] = mk(1, 0, 2'b11, {5'd5, 5'd5}, DAB, 16'h0030, 1, 1, 2'b10, 16'h0030, DAB, 4'd6);
      vecs[11] = mk(1, 1, 2'b11, {5'd7, 5'd0}, DCD, 16'h0034, 1, 1, 2'b10, 16'h0034, DCD, 4'd7);
      vecs[12] = mk(1, 1, 2'b11, {5'd0, 5'd3}, DEF, 16'h0038, 1, 1, 2'b01, 16'h0038, DEF, 4'd8);
      vecs[13] = mk(1, 1, 2'b11, {5'd4, 5'd3}, DGH, 16'h003C, 1, 1, 2'b11, 16'h003C, DGH, 4'd9);
      vecs[14] = mk(0, 1, 2'b00, 10'd0, 64'd0, 16'h0000, 0, 1, 2'b00, 16'h0000, 64'd0, 4'd10);

      do_reset();
      chk("reset_valid", 64'(out_valid_o), 64'd0);
      chk("reset_ready", 64'(in_ready_o), 64'd1);
      chk("reset_pc", 64'(pc_o), 64'd0);
      chk("reset_wen", 64'(lane_wen_o), 64'd0);
      chk("reset_cnt", 64'(retire_cnt_o), 64'd0);

      for (int i = 0; i < 15; i++) begin
         in_valid_i   = vecs[i].iv;
         out_ready_i  = vecs[i].ordy;
         lane_wen_i   = vecs[i].wen;
         lane_waddr_i = vecs[i].waddr;
         lane_wdata_i = vecs[i].wdata;
         pc_i         = vecs[i].pc;
         step();
         $display("vec %0d: valid=%0b ready=%0b wen=%b pc=%h cnt=%0d", i, out_valid_o,
                  in_ready_o, lane_wen_o, pc_o, retire_cnt_o);
         chk($sformatf("v%0d_valid", i), 64'(out_valid_o), 64'(vecs[i].e_valid));
         chk($sformatf("v%0d_ready", i), 64'(in_ready_o), 64'(vecs[i].e_ready));
         chk($sformatf("v%0d_wen", i), 64'(lane_wen_o), 64'(vecs[i].e_wen));
         chk($sformatf("v%0d_pc", i), 64'(pc_o), 64'(vecs[i].e_pc));
         chk($sformatf("v%0d_wdata", i), lane_wdata_o, vecs[i].e_wdata);
         chk($sformatf("v%0d_cnt", i), 64'(retire_cnt_o), 64'(vecs[i].e_cnt));
      end

      // Flush with the skid full and a live input offer
      lane_wen_i = '0; lane_waddr_i = '0; lane_wdata_i = '0;
      in_valid_i = 1'b1; out_ready_i = 1'b0; pc_i = 16'h0040; step();
      pc_i = 16'h0044; step();
      chk("fill_ready", 64'(in_ready_o), 64'd0);
      flush_i = 1'b1; out_ready_i = 1'b1; pc_i = 16'h0048; step();
      $display("flush: valid=%0b ready=%0b pc=%h cnt=%0d", out_valid_o, in_ready_o, pc_o,
               retire_cnt_o);
      chk("flush_valid", 64'(out_valid_o), 64'd0);
      chk("flush_ready", 64'(in_ready_o), 64'd1);
      chk("flush_cnt", 64'(retire_cnt_o), 64'd10);
      chk("flush_pc", 64'(pc_o), 64'd0);
      flush_i = 1'b0; in_valid_i = 1'b0; step();
      chk("post_flush_valid", 64'(out_valid_o), 64'd0);
      chk("post_flush_cnt", 64'(retire_cnt_o), 64'd10);

      // 17 retires wrap a 4-bit counter to 1
      do_reset();
      out_ready_i = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid_i = 1'b1; pc_i = 16'h0100 + 16'(i);
         step();
         chk($sformatf("wrap_pc%0d", i), 64'(pc_o), 64'(16'h0100 + 16'(i)));
      end
      in_valid_i = 1'b0; step();
      $display("wrap: valid=%0b cnt=%0d", out_valid_o, retire_cnt_o);
      chk("wrap_cnt", 64'(retire_cnt_o), 64'd1);
      chk("wrap_valid", 64'(out_valid_o), 64'd0);

      // Asynchronous reset between clock edges
      in_valid_i = 1'b1; out_ready_i = 1'b0; pc_i = 16'h0200; lane_wen_i = 2'b01;
      lane_waddr_i = {5'd0, 5'd9}; lane_wdata_i = DAB; step();
      pc_i = 16'h0204; step();
      chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
      #3 rst = 1'b0;
      #1;
      $display("async rst: valid=%0b ready=%0b pc=%h cnt=%0d", out_valid_o, in_ready_o, pc_o,
               retire_cnt_o);
      chk("arst_valid", 64'(out_valid_o), 64'd0);
      chk("arst_ready", 64'(in_ready_o), 64'd1);
      chk("arst_pc", 64'(pc_o), 64'd0);
      chk("arst_wen", 64'(lane_wen_o), 64'd0);
      chk("arst_wdata", lane_wdata_o, 64'd0);
      chk("arst_cnt", 64'(retire_cnt_o), 64'd0);
      in_valid_i = 1'b0;
      #2 rst = 1'b1;
      step();
      chk("post_rst_valid", 64'(out_valid_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
